// File: rtl/piece_window_probe_pkg.sv
// Shared game types for the piece window probe.
// Board geometry, board state, probe mode and FSM encodings.
package piece_window_probe_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef struct packed {
    logic [BOARD_W-1:0][BOARD_H-1:0] screen;
  } game_state_t;

  typedef enum logic {
    PROBE_SAMPLE  = 1'b0,
    PROBE_COLLIDE = 1'b1
  } probe_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } probe_fsm_t;

  function automatic logic in_board(
    input int wx,
    input int wy,
    input int w,
    input int h
  );
    return (wx >= 0) && (wy >= 0) && (wx < w) && (wy < h);
  endfunction

  // Mux-based read so a signed coordinate never has to be truncated
  function automatic logic board_bit(
    input game_state_t s,
    input int          x,
    input int          y
  );
    logic [BOARD_H-1:0] col;
    logic               r;
    col = '0;
    r   = 1'b0;
    for (int i = 0; i < BOARD_W; i++)
      if (i == x) col = s.screen[i];
    for (int j = 0; j < BOARD_H; j++)
      if (j == y) r = col[j];
    return r;
  endfunction

endpackage

// File: rtl/piece_window_probe_row_sampler.sv
// Combinational sampler for one window row.
// Off-board cells take the fill value.
module probe_row_sampler
  import piece_window_probe_pkg::*;
#(
  parameter int BOARD_WIDTH  = BOARD_W,
  parameter int BOARD_HEIGHT = BOARD_H,
  parameter int WIN_W        = 6,
  parameter int ORIGIN_DX    = 1,
  parameter int ORIGIN_DY    = 1,
  parameter bit OOB_FILL     = 1'b1,
  parameter int XW           = 4,
  parameter int YW           = 5,
  parameter int CW           = 3
) (
  input  game_state_t      state,
  input  logic [XW-1:0]    ax,
  input  logic [YW-1:0]    ay,
  input  logic [CW-1:0]    ly,
  output logic [WIN_W-1:0] cells
);

  int wx;
  int wy;

  // Map each window column of row ly onto the board, signed
  always_comb begin
    cells = '0;
    wx    = 0;
    wy    = int'(ay) - ORIGIN_DY + int'(ly);
    for (int lx = 0; lx < WIN_W; lx++) begin
      wx = int'(ax) - ORIGIN_DX + lx;
      if (in_board(wx, wy, BOARD_WIDTH, BOARD_HEIGHT))
        cells[lx] = board_bit(state, wx, wy);
      else
        cells[lx] = OOB_FILL;
    end
  end

endmodule

// File: rtl/piece_window_probe.sv
// Piece window probe: samples a window around an anchor,
// one row per cycle, with optional collision test.
module piece_window_probe
  import piece_window_probe_pkg::*;
#(
  parameter int BOARD_WIDTH  = BOARD_W,
  parameter int BOARD_HEIGHT = BOARD_H,
  parameter int WIN_W        = 6,
  parameter int WIN_H        = 6,
  parameter int ORIGIN_DX    = 1,
  parameter int ORIGIN_DY    = 1,
  parameter bit OOB_FILL     = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  game_state_t                         state,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [$clog2(BOARD_WIDTH)-1:0]      req_x,
  input  logic [$clog2(BOARD_HEIGHT)-1:0]     req_y,
  input  logic                                req_mode,
  input  logic [WIN_W-1:0][WIN_H-1:0]         req_shape,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [WIN_W-1:0][WIN_H-1:0]         rsp_window,
  output logic                                rsp_collide
);

  localparam int XW = $clog2(BOARD_WIDTH);
  localparam int YW = $clog2(BOARD_HEIGHT);
  localparam int CW = $clog2(WIN_H + 1);

  probe_fsm_t                  st;
  logic [CW-1:0]               row;
  logic [XW-1:0]               cap_x;
  logic [YW-1:0]               cap_y;
  probe_mode_t                 cap_mode;
  logic [WIN_W-1:0][WIN_H-1:0] cap_shape;
  logic [WIN_W-1:0][WIN_H-1:0] win;
  logic                        collide;
  logic [WIN_W-1:0]            cells;
  logic [WIN_W-1:0]            hit;

  probe_row_sampler #(
    .BOARD_WIDTH (BOARD_WIDTH),
    .BOARD_HEIGHT(BOARD_HEIGHT),
    .WIN_W       (WIN_W),
    .ORIGIN_DX   (ORIGIN_DX),
    .ORIGIN_DY   (ORIGIN_DY),
    .OOB_FILL    (OOB_FILL),
    .XW          (XW),
    .YW          (YW),
    .CW          (CW)
  ) u_row (
    .state(state),
    .ax   (cap_x),
    .ay   (cap_y),
    .ly   (row),
    .cells(cells)
  );

  // Overlap of the row being sampled with the captured piece mask
  always_comb begin
    hit = '0;
    for (int lx = 0; lx < WIN_W; lx++)
      hit[lx] = cells[lx] & cap_shape[lx][row];
  end

  // Request capture, row scan and response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      row       <= '0;
      cap_x     <= '0;
      cap_y     <= '0;
      cap_mode  <= PROBE_SAMPLE;
      cap_shape <= '0;
      win       <= '0;
      collide   <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (req_valid) begin
            cap_x     <= req_x;
            cap_y     <= req_y;
            cap_mode  <= probe_mode_t'(req_mode);
            cap_shape <= req_shape;
            row       <= '0;
            collide   <= 1'b0;
            st        <= SCAN;
          end
        end
        SCAN: begin
          for (int lx = 0; lx < WIN_W; lx++)
            win[lx][row] <= cells[lx];
          if (cap_mode == PROBE_COLLIDE && |hit)
            collide <= 1'b1;
          if (row == CW'(WIN_H - 1)) begin
            row <= '0;
            st  <= DONE;
          end else begin
            row <= row + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready)
            st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign req_ready   = (st == IDLE);
  assign rsp_valid   = (st == DONE);
  assign rsp_window  = win;
  assign rsp_collide = collide;

endmodule

// File: tb/tb_piece_window_probe.sv
// Scoreboard bench for piece_window_probe.
// Runs an OOB_FILL=1 and an OOB_FILL=0 instance in lockstep.
module tb_piece_window_probe;
  import piece_window_probe_pkg::*;

  localparam int WW = 6;
  localparam int WH = 6;

  typedef logic [WW-1:0][WH-1:0] win_t;

  typedef struct {
    win_t w1;
    win_t w0;
    logic c1;
    logic c0;
  } exp_t;

  exp_t sb[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  game_state_t state;
  logic        req_valid;
  logic        req_mode;
  logic        rsp_ready;
  logic [3:0]  req_x;
  logic [4:0]  req_y;
  win_t        req_shape;
  logic        ready1, ready0, valid1, valid0;
  win_t        win1, win0;
  logic        col1, col0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piece_window_probe #(.OOB_FILL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .req_valid(req_valid), .req_ready(ready1),
    .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
    .req_shape(req_shape), .rsp_valid(valid1),
    .rsp_ready(rsp_ready), .rsp_window(win1),
    .rsp_collide(col1)
  );

  piece_window_probe #(.OOB_FILL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .state(state),
    .req_valid(req_valid), .req_ready(ready0),
    .req_x(req_x), .req_y(req_y), .req_mode(req_mode),
    .req_shape(req_shape), .rsp_valid(valid0),
    .rsp_ready(rsp_ready), .rsp_window(win0),
    .rsp_collide(col0)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic game_state_t rand_board();
    game_state_t b;
    for (int x = 0; x < BOARD_W; x++)
      for (int y = 0; y < BOARD_H; y++)
        b.screen[x][y] = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int lx = 0; lx < WW; lx++)
      for (int ly = 0; ly < WH; ly++)
        w[lx][ly] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // Rows ly < sw see board a, later rows see board b
  function automatic win_t model(input game_state_t a,
                                 input game_state_t b,
                                 input int sw, input int x,
                                 input int y, input bit oob);
    win_t w;
    int   wx, wy;
    for (int lx = 0; lx < WW; lx++)
      for (int ly = 0; ly < WH; ly++) begin
        wx = x - 1 + lx;
        wy = y - 1 + ly;
        if (wx < 0 || wy < 0 || wx >= BOARD_W || wy >= BOARD_H)
          w[lx][ly] = oob;
        else if (ly < sw)
          w[lx][ly] = a.screen[wx][wy];
        else
          w[lx][ly] = b.screen[wx][wy];
      end
    return w;
  endfunction

  task automatic run_req(input int x, input int y, input bit mode,
                         input win_t shape, input game_state_t bb,
                         input int sw, input int hold);
    exp_t        e;
    game_state_t a;
    int          c;
    a         = state;
    req_x     = 4'(x);
    req_y     = 5'(y);
    req_mode  = mode;
    req_shape = shape;
    req_valid = 1'b1;
    @(posedge clk); #1;
    chk("busy_ready", ready1, 0);
    e.w1 = model(a, bb, sw, x, y, 1'b1);
    e.w0 = model(a, bb, sw, x, y, 1'b0);
    e.c1 = mode & (|(e.w1 & shape));
    e.c0 = mode & (|(e.w0 & shape));
    sb.push_back(e);
    // Busy: keep req_valid high with garbage, must be ignored
    req_x     = 4'($urandom_range(0, 9));
    req_y     = 5'($urandom_range(0, 19));
    req_mode  = ~mode;
    req_shape = rand_win();
    c = 0;
    while (!valid1 && c < 20) begin
      if (c == sw) state = bb;
      @(posedge clk); #1;
      c++;
    end
    chk("latency", c, WH);
    if (!valid1) begin
      sb.delete();
    end else begin
      e = sb.pop_front();
      chk("win1", win1, e.w1);
      chk("col1", col1, e.c1);
      chk("win0", win0, e.w0);
      chk("col0", col0, e.c0);
      chk("valid0", valid0, 1);
      if (hold > 0) begin
        state = rand_board();
        repeat (hold) begin
          @(posedge clk); #1;
        end
        chk("hold_win", win1, e.w1);
        chk("hold_col", col1, e.c1);
        chk("hold_ready", ready1, 0);
        chk("hold_valid", valid1, 1);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_valid", valid1, 0);
    chk("post_ready", ready1, 1);
  endtask

  initial begin
    game_state_t b;
    win_t        sh;
    state     = '0;
    req_valid = 1'b0;
    req_mode  = 1'b0;
    rsp_ready = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_shape = '0;
    #12;
    chk("rst_ready", ready1, 1);
    chk("rst_valid", valid1, 0);
    chk("rst_win", win1, 0);
    chk("rst_col", col1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Empty board, sample only
    state = '0;
    run_req(4, 5, 1'b0, rand_win(), state, WH, 0);

    // Top-left corner: column 0 and row 0 off-board
    state = rand_board();
    run_req(0, 0, 1'b1, rand_win(), state, WH, 0);

    // Bottom-right corner with screen[9][19] set
    state = rand_board();
    state.screen[9][19] = 1'b1;
    run_req(9, 19, 1'b0, '0, state, WH, 0);
    chk("far_11", win0[1][1], 1);
    chk("far_22", win0[2][2], 0);

    // Collision hit and miss
    state = '0;
    state.screen[5][6] = 1'b1;
    sh = '0;
    sh[2][2] = 1'b1;
    run_req(4, 5, 1'b1, sh, state, WH, 0);
    sh = '0;
    sh[3][3] = 1'b1;
    run_req(4, 5, 1'b1, sh, state, WH, 0);

    // Board rows change after two rows are sampled, then hold
    state = '0;
    b = '0;
    for (int x = 0; x < BOARD_W; x++) begin
      b.screen[x][4] = 1'b1;
      b.screen[x][8] = 1'b1;
    end
    run_req(4, 5, 1'b0, '0, b, 2, 10);

    // Random traffic
    for (int i = 0; i < 5; i++) begin
      state = rand_board();
      b = rand_board();
      run_req($urandom_range(0, 9), $urandom_range(0, 19),
              1'($urandom_range(0, 1)), rand_win(), b,
              $urandom_range(1, WH), $urandom_range(0, 3));
    end

    // Reset in the middle of a scan
    state     = rand_board();
    req_x     = 4'd3;
    req_y     = 5'd7;
    req_mode  = 1'b1;
    req_shape = rand_win();
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready1, 1);
    chk("mid_rst_valid", valid1, 0);
    chk("mid_rst_win", win1, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    state = rand_board();
    run_req(3, 7, 1'b1, rand_win(), state, WH, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
